shift_exec_stage: RTL and testbench

Execute-stage shift unit for RV32I SLL/SRL/SRA/SLLI/SRLI/SRAI.
- Decodes the shift operation and selects the shift amount.
- Feeds the combinational right barrel shifter; left shifts use bit-reversal around it.
- Registers the result toward writeback behind a valid/ready handshake with a one-entry skid buffer.
- Sits between the decode/issue register and the writeback mux.

---
 rtl/shift_pkg.sv | 35 +++
 rtl/right_barrel_shifter.sv | 34 +++
 rtl/shift_exec_stage.sv | 140 ++++++++++++++
 tb/tb_shift_exec_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared decode constants, state and result types for the
//               execute-stage shift unit.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SR  = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } shift_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } shift_res_t;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/right_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : right_barrel_shifter
// Description : Combinational logarithmic right shifter, logical or arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module right_barrel_shifter #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [XLEN-1:0]    idata,
    input  logic [SHAMT_W-1:0] shift_len,
    input  logic               arithmetic,
    output logic [XLEN-1:0]    odata
);

    logic                         w_fill;
    logic [SHAMT_W:0][XLEN-1:0]   w_stage;

    assign w_fill     = arithmetic & idata[XLEN-1];
    assign w_stage[0] = idata;

    // Stage k shifts by 2**k when bit k of the amount is set.
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        assign w_stage[gi+1] = shift_len[gi]
                             ? {{SH{w_fill}}, w_stage[gi][XLEN-1:SH]}
                             : w_stage[gi];
    end

    assign odata = w_stage[SHAMT_W];

endmodule
`default_nettype wire

// File: rtl/shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_exec_stage
// Description : RV32I execute-stage shift unit with registered output and a
//               one-entry skid buffer behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_funct3,
    input  logic               in_funct7_5,
    input  logic               in_is_imm,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [SHAMT_W-1:0] in_shamt_imm,
    input  logic [4:0]         in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [4:0]         out_rd,
    output logic               out_illegal
);

    logic [SHAMT_W-1:0] w_shamt;
    logic               w_is_sll;
    logic               w_is_srl;
    logic               w_is_sra;
    logic               w_illegal;
    logic [XLEN-1:0]    w_shift_in;
    logic [XLEN-1:0]    w_shift_out;
    logic               w_accept;
    logic               w_xfer;
    logic               w_unused_rs2;
    shift_res_t         w_new;

    shift_state_t       r_state;
    shift_res_t         r_out;
    shift_res_t         r_skid;
    logic               r_out_valid;
    logic               r_in_ready;

    assign w_unused_rs2 = &{1'b0, in_rs2_data[XLEN-1:SHAMT_W]};

    assign w_shamt   = in_is_imm ? in_shamt_imm : in_rs2_data[SHAMT_W-1:0];
    assign w_is_sll  = (in_funct3 == FUNCT3_SLL) && !in_funct7_5;
    assign w_is_srl  = (in_funct3 == FUNCT3_SR)  && !in_funct7_5;
    assign w_is_sra  = (in_funct3 == FUNCT3_SR)  &&  in_funct7_5;
    assign w_illegal = !(w_is_sll || w_is_srl || w_is_sra);

    // Left shifts reuse the right shifter by mirroring operand and result.
    assign w_shift_in = w_is_sll ? bit_reverse32(in_rs1_data) : in_rs1_data;

    right_barrel_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_rbs (
        .idata      (w_shift_in),
        .shift_len  (w_shamt),
        .arithmetic (w_is_sra),
        .odata      (w_shift_out)
    );

    always_comb begin
        w_new         = '0;
        w_new.rd      = in_rd;
        w_new.illegal = w_illegal;
        if (!w_illegal) begin
            w_new.result = w_is_sll ? bit_reverse32(w_shift_out) : w_shift_out;
        end
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out       <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            // Any transfer this cycle completes; held and incoming ops are dropped.
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_out       <= w_new;
                        r_out_valid <= 1'b1;
                        r_state     <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_xfer) begin
                        r_out <= w_new;
                    end else if (w_accept) begin
                        r_skid     <= w_new;
                        r_in_ready <= 1'b0;
                        r_state    <= SKID;
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (w_xfer) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= FULL;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_result  = r_out.result;
    assign out_rd      = r_out.rd;
    assign out_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_exec_stage
// Description : Self-checking bench: directed steps plus random traffic against
//               a queue-based arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_exec_stage;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic        in_is_imm;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_shamt_imm;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[$];

    logic        hold;
    logic [31:0] h_res;
    logic [4:0]  h_rd;
    logic        h_ill;

    shift_exec_stage #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_funct7_5  (in_funct7_5),
        .in_is_imm    (in_is_imm),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_shamt_imm (in_shamt_imm),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic imm,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [4:0] sh_imm, input logic [4:0] rd);
        exp_t e;
        int   sh;
        sh        = imm ? int'(sh_imm) : int'(rs2 % 32);
        e.rd      = rd;
        e.illegal = 1'b0;
        e.result  = 32'h0;
        if (f3 == 3'b001 && !f7)      e.result = rs1 << sh;
        else if (f3 == 3'b101 && !f7) e.result = rs1 >> sh;
        else if (f3 == 3'b101 && f7)  e.result = 32'($signed(rs1) >>> sh);
        else                          e.illegal = 1'b1;
        return e;
    endfunction

    task automatic set_op(input logic [2:0] f3, input logic f7, input logic imm,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] sh_imm, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_funct3    = f3;
        in_funct7_5  = f7;
        in_is_imm    = imm;
        in_rs1_data  = rs1;
        in_rs2_data  = rs2;
        in_shamt_imm = sh_imm;
        in_rd        = rd;
    endtask

    // One clock: handshake checks, model update, then advance to edge+1.
    task automatic cycle();
        logic acc;
        logic xf;
        if (hold) begin
            chk("hold_result", out_result, h_res);
            chk("hold_rd", 32'(out_rd), 32'(h_rd));
            chk("hold_illegal", 32'(out_illegal), 32'(h_ill));
        end
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
        if (xf && q.size() > 0) begin
            chk("xfer_result", out_result, q[0].result);
            chk("xfer_rd", 32'(out_rd), 32'(q[0].rd));
            chk("xfer_illegal", 32'(out_illegal), 32'(q[0].illegal));
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (acc) q.push_back(model(in_funct3, in_funct7_5, in_is_imm, in_rs1_data,
                                        in_rs2_data, in_shamt_imm, in_rd));
        hold  = out_valid && !out_ready && !flush;
        h_res = out_result;
        h_rd  = out_rd;
        h_ill = out_illegal;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; hold = 1'b0;
        h_res = '0; h_rd = '0; h_ill = 1'b0;
        set_op(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        in_valid = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SRAI sign fill
        out_ready = 1'b1;
        set_op(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 5'd4, 5'd5);
        cycle(); in_valid = 1'b0;
        chk("srai_valid", 32'(out_valid), 32'd1);
        chk("srai_result", out_result, 32'hF800_0000);
        chk("srai_illegal", 32'(out_illegal), 32'd0);
        chk("srai_in_ready", 32'(in_ready), 32'd1);
        cycle();

        // SLL register form, upper rs2 bits ignored
        set_op(3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFE3, 5'd0, 5'd6);
        cycle(); in_valid = 1'b0;
        chk("sll_result", out_result, 32'h0000_0008);
        cycle();
        set_op(3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 5'd31, 5'd7);
        cycle(); in_valid = 1'b0;
        chk("srl31_result", out_result, 32'h0000_0001);
        cycle();
        set_op(3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'hFFFF_FFE0, 5'd9, 5'd8);
        cycle(); in_valid = 1'b0;
        chk("sra0_result", out_result, 32'h8765_4321);
        cycle();

        // Backpressure into the skid buffer
        out_ready = 1'b0;
        set_op(3'b101, 1'b0, 1'b1, 32'h0000_00F0, 32'h0, 5'd4, 5'd10);
        cycle();
        set_op(3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'h0, 5'd1, 5'd11);
        cycle(); in_valid = 1'b0;
        chk("skid_in_ready", 32'(in_ready), 32'd0);
        chk("skid_result_a", out_result, 32'h0000_000F);
        cycle();
        chk("skid_hold_a", out_result, 32'h0000_000F);
        out_ready = 1'b1;
        cycle();
        chk("skid_result_b", out_result, 32'h0000_0002);
        chk("skid_valid_b", 32'(out_valid), 32'd1);
        cycle();
        chk("skid_drained", 32'(out_valid), 32'd0);

        // Illegal encodings
        set_op(3'b000, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h3, 5'd3, 5'd19);
        cycle(); in_valid = 1'b0;
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_result", out_result, 32'h0);
        chk("ill_rd", 32'(out_rd), 32'd19);
        set_op(3'b001, 1'b1, 1'b1, 32'h1, 32'h0, 5'd2, 5'd20);
        cycle(); in_valid = 1'b0;
        chk("slli_f7_ill", 32'(out_illegal), 32'd1);
        cycle();

        // Flush while in SKID with an incoming op
        out_ready = 1'b0;
        set_op(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd1, 5'd1);
        cycle();
        set_op(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd2, 5'd2);
        cycle();
        set_op(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd3, 5'd3);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        cycle(); cycle();

        // Flush in FULL drops the op accepted that cycle
        out_ready = 1'b0;
        set_op(3'b101, 1'b0, 1'b1, 32'hFF, 32'h0, 5'd1, 5'd4);
        cycle();
        set_op(3'b101, 1'b0, 1'b1, 32'hFF, 32'h0, 5'd2, 5'd5);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        cycle();
        chk("flush_full_dropped", 32'(out_valid), 32'd0);

        // Asynchronous reset in SKID
        set_op(3'b101, 1'b0, 1'b1, 32'hF0, 32'h0, 5'd4, 5'd12);
        cycle();
        set_op(3'b101, 1'b0, 1'b1, 32'hF0, 32'h0, 5'd2, 5'd13);
        cycle(); in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_result", out_result, 32'h0);
        q.delete(); hold = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_op(3'b001, 1'b0, 1'b0, 32'h0000_0003, 32'h4, 5'd0, 5'd14);
        cycle(); in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_result", out_result, 32'h0000_0030);
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0] f3;
            logic       f7;
            case ($urandom_range(0, 9))
                0, 1, 2, 3:       f3 = 3'b001;
                4, 5, 6, 7, 8:    f3 = 3'b101;
                default:          f3 = 3'($urandom);
            endcase
            f7 = (f3 == 3'b101) ? 1'($urandom) : ($urandom_range(0, 5) == 0);
            set_op(f3, f7, 1'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
